acc_ctrl_seq: RTL and testbench
===============================

Name: acc_ctrl_seq

Overview:
- Multi-cycle fetch/decode/execute sequencer for the 8-bit accumulator processor.
- Sits directly upstream of the ALU and drives its operands and `alu_sel`.
- Consumes the ALU result and its z/c flags.
- Owns the PC, the instruction register, the accumulator, a 4x8 register file and the flag register.

Parameters:
PC_W, 8, program counter width in bits; wraps modulo 2^PC_W.

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous active-high reset
pc  out  PC_W  instruction memory address
instr_in  in  8  instruction word for address pc
instr_vld  in  1  instr_in valid this cycle
alu_a  out  8  ALU operand A (always acc)
alu_b  out  8  ALU operand B (R[rr])
alu_sel  out  3  ALU opcode
alu_res  in  8  ALU combinational result
alu_z  in  1  ALU zero flag (ALU registers it on clk)
alu_c  in  1  ALU carry/borrow (valid for sel 000/001 only)
acc  out  8  accumulator
zf  out  1  latched zero flag
cf  out  1  latched carry flag
halted  out  1  high once HALT has executed
state  out  2  FSM state, for debug

Behaviour:
- Reset (async, immediate), while rst is high:
  - pc=0, acc=0, R0..R3=0, IR=0, zf=0, cf=0, halted=0.
  - alu_a=0, alu_b=0, alu_sel=000, state=FETCH.
  - Reset mid-instruction aborts it: no acc/register/flag write.
- States: FETCH=0, DECODE=1, EXECUTE=2, WRITEBACK=3. HALT is a terminal condition flagged by halted=1, with state held at EXECUTE.
- FETCH:
  - Waits while instr_vld=0; pc and everything else hold.
  - When instr_vld=1: IR<=instr_in, pc<=pc+1 (wraps to 0 from 2^PC_W-1), go to DECODE.
- DECODE:
  - Register alu_a<=acc, alu_b<=R[IR[1:0]].
  - If IR[7]=0: alu_sel<=IR[6:4].
  - Go to EXECUTE.
- Encoding, with rr=IR[1:0] and n=IR[3:0]:
  - 0sss_xxrr: ALU op sss, B=R[rr]; NOT/shifts ignore B.
  - 1000_xxrr: MOV R[rr]<=acc.
  - 1001_xxrr: MOV acc<=R[rr].
  - 1010_nnnn: LDI acc<={4'b0,n}.
  - 1011_nnnn: JZ, if zf then pc<=n zero-extended.
  - 1100_nnnn: JC, if cf then pc<=n zero-extended.
  - 1101_nnnn: JMP, pc<=n zero-extended.
  - 1110_xxxx: NOP.
  - 1111_xxxx: HALT.
- EXECUTE:
  - ALU op: operands and alu_sel held stable; go to WRITEBACK.
  - Non-ALU op: perform the action at the end of this cycle, go to FETCH.
  - HALT: halted<=1, stay in EXECUTE forever until reset; pc stays at HALT address+1.
- WRITEBACK (ALU op only):
  - acc<=alu_res; zf<=alu_z (the ALU's z is valid here because it updated on the EXECUTE->WRITEBACK edge).
  - cf<=alu_c only if alu_sel is 000 or 001; otherwise cf holds.
  - alu_a/alu_b/alu_sel held through this cycle. Go to FETCH.
- Flags change only in WRITEBACK. MOV/LDI/jumps never touch zf/cf.
- Latency, counting from instr_vld sampled high: ALU op 4 cycles; other ops 3 cycles.
- Arithmetic and width:
  - All data paths are 8 bits.
  - Jump targets are zero-extended, or truncated if PC_W<4.
  - pc+1 wraps silently.
- Simultaneous events:
  - A jump in EXECUTE overrides the pc+1 from FETCH.
  - A jump to its own address loops legally.

Test Plan:
- Reset mid-WRITEBACK of ADD, then release:
  - Required: acc=0, zf=0, cf=0, pc=0, state=FETCH.
  - Next fetch is from address 0.
- Program A5,81,A3,01 with instr_vld always high:
  - Required after 13 cycles: R1=05, acc=08, zf=0, cf=0, pc=4.
  - The ADD takes exactly 4 cycles.
- Program A0,40,82,A1,02,C9 (LDI 0, NOT, MOV R2, LDI 1, ADD R2, JC 9):
  - Required: acc=00, zf=1, cf=1.
  - JC taken, pc=9 after the JC's EXECUTE.
- Program A8,80,10 (acc=8, R0=8, SUB R0), then B3 (JZ 3) and C3 (JC 3):
  - Required: acc=00, zf=1, cf=0.
  - JZ taken to pc=3; JC not taken.
- Hold instr_vld=0 for 5 cycles in FETCH:
  - Required: pc, IR and state frozen.
  - Instruction accepted on the first cycle instr_vld=1.
- PC_W=4, program ends with E0 at address F:
  - Required: pc wraps to 0.
- Separately, HALT (F0): halted=1, state holds at 2, and pc, acc and flags stay constant for 20 cycles.

Source files
------------

// File: rtl/acc_ctrl_seq.sv
// acc_ctrl_seq: multi-cycle fetch/decode/execute/writeback sequencer for the
// 8-bit accumulator processor. It owns the PC, instruction register,
// accumulator, a 4x8 register file and the z/c flag register, and drives the
// operands and opcode of an external combinational ALU.
//
// Ports:
//   clk, rst           rising-edge clock, asynchronous active-high reset
//   pc                 instruction memory address
//   instr_in/instr_vld instruction word for pc and its valid strobe
//   alu_a/alu_b        ALU operands (acc, R[rr]) latched in DECODE
//   alu_sel            ALU opcode latched in DECODE for ALU instructions
//   alu_res/alu_z/alu_c ALU result, registered zero flag, carry/borrow
//   acc, zf, cf        accumulator and latched flags
//   halted             set once HALT has executed
//   state              FSM state (FETCH=0, DECODE=1, EXECUTE=2, WRITEBACK=3)
module acc_ctrl_seq #(
  parameter int PC_W = 8
) (
  input  logic            clk,
  input  logic            rst,
  output logic [PC_W-1:0] pc,
  input  logic [7:0]      instr_in,
  input  logic            instr_vld,
  output logic [7:0]      alu_a,
  output logic [7:0]      alu_b,
  output logic [2:0]      alu_sel,
  input  logic [7:0]      alu_res,
  input  logic            alu_z,
  input  logic            alu_c,
  output logic [7:0]      acc,
  output logic            zf,
  output logic            cf,
  output logic            halted,
  output logic [1:0]      state
);

  typedef enum logic [1:0] {
    ST_FETCH     = 2'd0,
    ST_DECODE    = 2'd1,
    ST_EXECUTE   = 2'd2,
    ST_WRITEBACK = 2'd3
  } state_t;

  // Non-ALU opcodes (IR[7]=1), selected by IR[6:4]
  localparam logic [2:0] OP_MOV_RA = 3'd0;  // R[rr] <= acc
  localparam logic [2:0] OP_MOV_AR = 3'd1;  // acc <= R[rr]
  localparam logic [2:0] OP_LDI    = 3'd2;
  localparam logic [2:0] OP_JZ     = 3'd3;
  localparam logic [2:0] OP_JC     = 3'd4;
  localparam logic [2:0] OP_JMP    = 3'd5;
  localparam logic [2:0] OP_HALT   = 3'd7;

  localparam logic [PC_W-1:0] PC_ONE = 1;

  state_t          r_state;
  state_t          w_state_next;
  logic [PC_W-1:0] r_pc;
  logic [7:0]      r_ir;
  logic [7:0]      r_acc;
  logic            r_zf;
  logic            r_cf;
  logic            r_halted;
  logic [7:0]      r_alu_a;
  logic [7:0]      r_alu_b;
  logic [2:0]      r_alu_sel;
  logic [7:0]      r_rf [4];
  logic [3:0]      w_rf_we;

  logic            w_is_alu;
  logic [2:0]      w_op;
  logic [1:0]      w_rr;
  logic [PC_W-1:0] w_target;
  logic            w_exec_ctl;

  assign w_is_alu   = ~r_ir[7];
  assign w_op       = r_ir[6:4];
  assign w_rr       = r_ir[1:0];
  // Size cast zero-extends for wide PCs and truncates when PC_W < 4
  assign w_target   = PC_W'(r_ir[3:0]);
  assign w_exec_ctl = (r_state == ST_EXECUTE) && r_ir[7];

  // Register file: one write port, written only by MOV R[rr] <= acc
  for (genvar gi = 0; gi < 4; gi++) begin : g_rf
    assign w_rf_we[gi] = w_exec_ctl && (w_op == OP_MOV_RA) && (w_rr == 2'(gi));

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_rf[gi] <= '0;
      end else if (w_rf_we[gi]) begin
        r_rf[gi] <= r_acc;
      end
    end
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_FETCH;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic; HALT parks the FSM in EXECUTE until reset
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_FETCH:     if (instr_vld) w_state_next = ST_DECODE;
      ST_DECODE:    w_state_next = ST_EXECUTE;
      ST_EXECUTE: begin
        if (w_is_alu) begin
          w_state_next = ST_WRITEBACK;
        end else if (w_op != OP_HALT) begin
          w_state_next = ST_FETCH;
        end
      end
      ST_WRITEBACK: w_state_next = ST_FETCH;
      default:      w_state_next = ST_FETCH;
    endcase
  end

  // Datapath: pc, IR, acc, flags, ALU operand registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc      <= '0;
      r_ir      <= '0;
      r_acc     <= '0;
      r_zf      <= 1'b0;
      r_cf      <= 1'b0;
      r_halted  <= 1'b0;
      r_alu_a   <= '0;
      r_alu_b   <= '0;
      r_alu_sel <= '0;
    end else begin
      case (r_state)
        ST_FETCH: begin
          if (instr_vld) begin
            r_ir <= instr_in;
            r_pc <= r_pc + PC_ONE;
          end
        end
        ST_DECODE: begin
          r_alu_a <= r_acc;
          r_alu_b <= r_rf[w_rr];
          // Non-ALU ops leave the previous opcode on the ALU
          if (w_is_alu) r_alu_sel <= w_op;
        end
        ST_EXECUTE: begin
          if (!w_is_alu) begin
            case (w_op)
              OP_MOV_AR: r_acc <= r_rf[w_rr];
              OP_LDI:    r_acc <= {4'b0000, r_ir[3:0]};
              OP_JZ:     if (r_zf) r_pc <= w_target;
              OP_JC:     if (r_cf) r_pc <= w_target;
              OP_JMP:    r_pc <= w_target;
              OP_HALT:   r_halted <= 1'b1;
              default:   ;  // MOV R<-acc is the register file's job; NOP
            endcase
          end
        end
        ST_WRITEBACK: begin
          r_acc <= alu_res;
          // alu_z was registered by the ALU on the EXECUTE->WRITEBACK edge
          r_zf  <= alu_z;
          // Carry is only meaningful for ADD (000) and SUB (001)
          if (r_alu_sel == 3'b000 || r_alu_sel == 3'b001) r_cf <= alu_c;
        end
        default: ;
      endcase
    end
  end

  assign pc      = r_pc;
  assign alu_a   = r_alu_a;
  assign alu_b   = r_alu_b;
  assign alu_sel = r_alu_sel;
  assign acc     = r_acc;
  assign zf      = r_zf;
  assign cf      = r_cf;
  assign halted  = r_halted;
  assign state   = r_state;

endmodule

// File: tb/tb_acc_ctrl_seq.sv
// Testbench for acc_ctrl_seq: directed programs plus a randomized program,
// checked by an instruction-level reference model through a scoreboard queue.
module tb_acc_ctrl_seq;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] pc;
  logic [7:0] instr_in = 8'h00;
  logic       instr_vld = 1'b0;
  logic [7:0] alu_a, alu_b, alu_res;
  logic [2:0] alu_sel;
  logic       alu_z = 1'b0;
  logic       alu_c;
  logic [7:0] acc;
  logic       zf, cf, halted;
  logic [1:0] state;

  // Second instance with a 4-bit PC for the wrap check
  logic       rst4 = 1'b1;
  logic [3:0] pc4;
  logic [7:0] instr_in4 = 8'hE0;
  logic       instr_vld4 = 1'b1;
  logic [7:0] alu_a4, alu_b4, acc4;
  logic [7:0] alu_res4 = 8'h00;
  logic       alu_z4 = 1'b0, alu_c4 = 1'b0;
  logic [2:0] alu_sel4;
  logic       zf4, cf4, halted4;
  logic [1:0] state4;

  always #5 clk = ~clk;

  acc_ctrl_seq #(.PC_W(8)) u_dut (
    .clk(clk), .rst(rst), .pc(pc), .instr_in(instr_in), .instr_vld(instr_vld),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_res(alu_res),
    .alu_z(alu_z), .alu_c(alu_c), .acc(acc), .zf(zf), .cf(cf),
    .halted(halted), .state(state)
  );

  acc_ctrl_seq #(.PC_W(4)) u_dut4 (
    .clk(clk), .rst(rst4), .pc(pc4), .instr_in(instr_in4), .instr_vld(instr_vld4),
    .alu_a(alu_a4), .alu_b(alu_b4), .alu_sel(alu_sel4), .alu_res(alu_res4),
    .alu_z(alu_z4), .alu_c(alu_c4), .acc(acc4), .zf(zf4), .cf(cf4),
    .halted(halted4), .state(state4)
  );

  // ALU: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 NOT, 101 XOR, 110 SHL, 111 SHR.
  // Carry output is noise for ops without a carry, so a leaking cf is visible.
  logic noise = 1'b0;
  always @(posedge clk) noise <= 1'($urandom);
  always_comb begin
    alu_res = 8'h00;
    alu_c   = noise;
    case (alu_sel)
      3'd0: {alu_c, alu_res} = {1'b0, alu_a} + {1'b0, alu_b};
      3'd1: {alu_c, alu_res} = {1'b0, alu_a} - {1'b0, alu_b};
      3'd2: alu_res = alu_a & alu_b;
      3'd3: alu_res = alu_a | alu_b;
      3'd4: alu_res = ~alu_a;
      3'd5: alu_res = alu_a ^ alu_b;
      3'd6: alu_res = {alu_a[6:0], 1'b0};
      default: alu_res = {1'b0, alu_a[7:1]};
    endcase
  end
  always @(posedge clk) alu_z <= (alu_res == 8'h00);

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Instruction-level reference model
  typedef struct {
    logic [7:0] acc;
    logic       zf;
    logic       cf;
    logic [7:0] pc;
    int         lat;
  } exp_t;

  exp_t       sb_q[$];
  logic [7:0] mem [256];
  logic [7:0] m_acc, m_pc;
  logic [7:0] m_r [4];
  logic       m_zf, m_cf;

  task automatic model_reset();
    m_acc = 0; m_pc = 0; m_zf = 0; m_cf = 0;
    for (int i = 0; i < 4; i++) m_r[i] = 0;
    sb_q.delete();
  endtask

  task automatic model_step(input logic [7:0] ins);
    exp_t       e;
    logic [8:0] t;
    logic [7:0] b;
    b = m_r[ins[1:0]];
    m_pc = m_pc + 8'd1;
    e.lat = 3;
    if (!ins[7]) begin
      e.lat = 4;
      case (ins[6:4])
        3'd0: begin t = {1'b0, m_acc} + {1'b0, b}; m_cf = t[8]; m_acc = t[7:0]; end
        3'd1: begin t = {1'b0, m_acc} - {1'b0, b}; m_cf = t[8]; m_acc = t[7:0]; end
        3'd2: m_acc = m_acc & b;
        3'd3: m_acc = m_acc | b;
        3'd4: m_acc = ~m_acc;
        3'd5: m_acc = m_acc ^ b;
        3'd6: m_acc = m_acc << 1;
        default: m_acc = m_acc >> 1;
      endcase
      m_zf = (m_acc == 0);
    end else begin
      case (ins[6:4])
        3'd0: m_r[ins[1:0]] = m_acc;
        3'd1: m_acc = m_r[ins[1:0]];
        3'd2: m_acc = {4'h0, ins[3:0]};
        3'd3: if (m_zf) m_pc = {4'h0, ins[3:0]};
        3'd4: if (m_cf) m_pc = {4'h0, ins[3:0]};
        3'd5: m_pc = {4'h0, ins[3:0]};
        default: ;
      endcase
    end
    e.acc = m_acc; e.zf = m_zf; e.cf = m_cf; e.pc = m_pc;
    sb_q.push_back(e);
  endtask

  // Cycles since the instruction in flight was accepted
  int cyc = 0;
  always @(posedge clk) begin
    if (rst) cyc <= 0;
    else if (state == 2'd0 && instr_vld) cyc <= 1;
    else cyc <= cyc + 1;
  end

  // Monitor: an instruction has completed when the FSM returns to FETCH
  logic [1:0] prev_st = 2'd0;
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      prev_st = 2'd0;
    end else begin
      if (state == 2'd0 && prev_st != 2'd0) begin
        if (sb_q.size() == 0) begin
          chk("sb_unexpected_completion", 32'd1, 32'd0);
        end else begin
          e = sb_q.pop_front();
          $display("retire pc=%02h acc=%02h zf=%0d cf=%0d lat=%0d",
                   pc, acc, zf, cf, cyc);
          chk("ret_acc", acc, e.acc);
          chk("ret_zf", zf, e.zf);
          chk("ret_cf", cf, e.cf);
          chk("ret_pc", pc, e.pc);
          chk("ret_latency", cyc, e.lat);
        end
      end
      prev_st = state;
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; instr_vld = 1'b0;
    @(negedge clk);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Issue n instructions from mem (stall = percent chance of idling in FETCH)
  task automatic run_prog(input int n, input int stall);
    int issued = 0;
    int guard  = 0;
    while ((issued < n || sb_q.size() != 0) && guard < 20000) begin
      @(negedge clk);
      guard++;
      if (state == 2'd0 && issued < n && $urandom_range(0, 99) >= stall) begin
        instr_vld = 1'b1;
        instr_in  = mem[m_pc];
        chk("fetch_pc", pc, m_pc);
        model_step(instr_in);
        issued++;
      end else begin
        instr_vld = 1'b0;
        instr_in  = 8'($urandom);
      end
    end
    instr_vld = 1'b0;
    chk("run_timeout", (guard < 20000), 1);
  endtask

  task automatic load(input logic [7:0] p [$]);
    for (int i = 0; i < 256; i++) mem[i] = 8'hE0;
    foreach (p[i]) mem[i] = p[i];
  endtask

  initial begin
    int guard;
    logic [7:0] prog [$];

    // Reset state
    @(negedge clk);
    chk("rst_pc", pc, 0);
    chk("rst_acc", acc, 0);
    chk("rst_flags", {zf, cf, halted}, 0);
    chk("rst_state", state, 0);
    chk("rst_alu", {alu_a, alu_b, 5'(alu_sel)}, 0);
    model_reset();
    rst = 1'b0;

    // LDI 5, MOV R1, LDI 3, ADD R1, then MOV acc<-R1
    prog = '{8'hA5, 8'h81, 8'hA3, 8'h01, 8'h91};
    load(prog);
    run_prog(4, 0);
    chk("progA_acc", acc, 8'h08);
    chk("progA_flags", {zf, cf}, 0);
    chk("progA_pc", pc, 4);
    run_prog(1, 0);
    chk("progA_r1", acc, 8'h05);

    // LDI 0, NOT, MOV R2, LDI 1, ADD R2, JC 9
    do_reset();
    prog = '{8'hA0, 8'h40, 8'h82, 8'hA1, 8'h02, 8'hC9};
    load(prog);
    run_prog(6, 0);
    chk("progB_acc", acc, 8'h00);
    chk("progB_flags", {zf, cf}, 2'b11);
    chk("progB_pc", pc, 9);

    // LDI 8, MOV R0, SUB R0, JZ 3 (taken, self-loop), then JC 3 (not taken)
    do_reset();
    prog = '{8'hA8, 8'h80, 8'h10, 8'hB3};
    load(prog);
    run_prog(4, 0);
    chk("progC_acc", acc, 8'h00);
    chk("progC_flags", {zf, cf}, 2'b10);
    chk("progC_jz_pc", pc, 3);
    mem[3] = 8'hC3;
    run_prog(1, 0);
    chk("progC_jc_pc", pc, 4);

    // Stall in FETCH for 5 cycles, then accept LDI 7
    do_reset();
    prog = '{8'hA7};
    load(prog);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      instr_vld = 1'b0;
      instr_in  = 8'($urandom);
      chk("stall_pc_state", {pc, 6'(state)}, 0);
    end
    @(negedge clk);
    instr_vld = 1'b1; instr_in = mem[0];
    model_step(instr_in);
    @(negedge clk);
    instr_vld = 1'b0;
    chk("stall_accept", {pc, 6'(state)}, {8'd1, 6'd1});
    run_prog(0, 0);
    chk("stall_acc", acc, 8'h07);

    // Reset during WRITEBACK of ADD
    do_reset();
    prog = '{8'hA5, 8'h81, 8'h01};
    load(prog);
    run_prog(2, 0);
    @(negedge clk);
    instr_vld = 1'b1; instr_in = mem[m_pc];
    model_step(instr_in);
    @(negedge clk);
    instr_vld = 1'b0;
    guard = 0;
    while (state != 2'd3 && guard < 20) begin @(negedge clk); guard++; end
    chk("wb_reached", state, 3);
    rst = 1'b1;
    #1;
    chk("abort_pc_acc", {pc, acc}, 0);
    chk("abort_flags", {zf, cf, halted}, 0);
    chk("abort_state", state, 0);
    chk("abort_alu", {alu_a, alu_b, 5'(alu_sel)}, 0);
    @(negedge clk);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    run_prog(1, 0);
    chk("abort_refetch_acc", acc, 8'h05);

    // HALT: everything frozen, state parked in EXECUTE
    do_reset();
    prog = '{8'hA5, 8'hF0};
    load(prog);
    run_prog(1, 0);
    @(negedge clk);
    instr_vld = 1'b1; instr_in = 8'hF0;
    @(negedge clk);
    instr_vld = 1'b0;
    guard = 0;
    while (!halted && guard < 10) begin @(negedge clk); guard++; end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      instr_vld = 1'(i % 2);
      instr_in  = 8'($urandom);
      chk("halt_hold", {halted, state, pc, acc, zf, cf},
          {1'b1, 2'd2, 8'd2, 8'h05, 1'b0, 1'b0});
    end
    instr_vld = 1'b0;

    // Randomized program (HALT replaced by NOP), random FETCH stalls
    do_reset();
    for (int i = 0; i < 256; i++) begin
      mem[i] = 8'($urandom);
      if (mem[i][7:4] == 4'hF) mem[i] = 8'hE0;
    end
    run_prog(400, 30);

    // PC_W=4 wrap: NOPs only, address F fetched then pc wraps to 0
    @(negedge clk);
    rst4 = 1'b0;
    repeat (45) @(posedge clk);
    #1;
    chk("wrap4_pc_before", pc4, 4'hF);
    @(posedge clk);
    #1;
    chk("wrap4_pc_after", {pc4, 2'b00, state4}, {4'h0, 2'b00, 2'd1});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
